// File: rtl/vx_tcu_drl_acc_pkg.sv
// Shared constants and helpers for the TCU accumulate (adder-tree) stage.
package vx_tcu_drl_acc_pkg;

  localparam int unsigned TCU_TAG_W = 32;

  // Number of lanes left after k pairwise-reduction levels: ceil(n / 2^k).
  function automatic int unsigned tcu_acc_lanes(input int unsigned n, input int unsigned k);
    return (n + (32'd1 << k) - 32'd1) >> k;
  endfunction

endpackage

// File: rtl/vx_tcu_drl_acc_level.sv
// One adder-tree level: sums lanes in pairs (2j, 2j+1), odd leftover lane passes through.
module vx_tcu_drl_acc_level
  import vx_tcu_drl_acc_pkg::*;
#(
  parameter int unsigned LANES_IN = 5,
  parameter int unsigned W        = 27,
  localparam int unsigned LANES_OUT = tcu_acc_lanes(LANES_IN, 1)
) (
  input  logic [LANES_IN*W-1:0]      lanes_i,
  output logic [LANES_OUT*(W+1)-1:0] lanes_o
);

  always_comb begin
    lanes_o = '0;
    for (int unsigned j = 0; j < LANES_IN / 2; j++) begin
      lanes_o[j*(W+1) +: W+1] =
          {lanes_i[(2*j)*W+W-1],   lanes_i[(2*j)*W +: W]} +
          {lanes_i[(2*j+1)*W+W-1], lanes_i[(2*j+1)*W +: W]};
    end
    // Leftover lane is sign-extended so every output lane has the same width.
    if (LANES_IN % 2 == 1) begin
      lanes_o[(LANES_OUT-1)*(W+1) +: W+1] =
          {lanes_i[LANES_IN*W-1], lanes_i[(LANES_IN-1)*W +: W]};
    end
  end

endmodule

// File: rtl/vx_tcu_drl_acc.sv
// Elastic pipelined adder tree: sums N aligned signed significands, ORs sticky, carries tags.
module vx_tcu_drl_acc
  import vx_tcu_drl_acc_pkg::*;
#(
  parameter string       INSTANCE_ID = "",
  parameter int unsigned N           = 5,
  parameter int unsigned WI          = 27,
  localparam int unsigned LEVELS     = $clog2(N),
  localparam int unsigned WS         = WI + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [TCU_TAG_W-1:0] req_id,
  input  logic                 is_int,
  input  logic [N*WI-1:0]      sigs_in,
  input  logic [N-1:0]         sticky_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [WS-1:0]        sum_out,
  output logic                 sticky_out,
  output logic                 is_int_out,
  output logic [TCU_TAG_W-1:0] req_id_out
);

  logic [LEVELS-1:0]    valid_q, valid_d;
  logic [LEVELS-1:0]    en, prev_valid, load;
  logic [LEVELS-1:0]    sticky_q, sticky_d;
  logic [LEVELS-1:0]    is_int_q, is_int_d;
  logic [TCU_TAG_W-1:0] req_q [LEVELS];
  logic [TCU_TAG_W-1:0] req_d [LEVELS];

  // Level k may load unless it and every level downstream are full and the sink is stalled.
  always_comb begin
    en = '0;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      en[k] = ready_out;
      for (int unsigned j = k; j < LEVELS; j++) begin
        if (!valid_q[j]) en[k] = 1'b1;
      end
    end
  end

  always_comb begin
    prev_valid    = '0;
    prev_valid[0] = valid_in;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      prev_valid[k] = valid_q[k-1];
    end
  end

  assign load = en & prev_valid;

  always_comb begin
    valid_d  = valid_q;
    sticky_d = sticky_q;
    is_int_d = is_int_q;
    req_d    = req_q;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      if (en[k]) valid_d[k] = prev_valid[k];
    end
    if (load[0]) begin
      sticky_d[0] = |sticky_in;
      is_int_d[0] = is_int;
      req_d[0]    = req_id;
    end
    for (int unsigned k = 1; k < LEVELS; k++) begin
      if (load[k]) begin
        sticky_d[k] = sticky_q[k-1];
        is_int_d[k] = is_int_q[k-1];
        req_d[k]    = req_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      sticky_q <= '0;
      is_int_q <= '0;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        req_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      is_int_q <= is_int_d;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        req_q[k] <= req_d[k];
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned LIn  = tcu_acc_lanes(N, k);
    localparam int unsigned LOut = tcu_acc_lanes(N, k + 1);
    localparam int unsigned WIn  = WI + k;

    logic [LIn*WIn-1:0]      lanes_in;
    logic [LOut*(WIn+1)-1:0] lanes_sum, data_d, data_q;

    if (k == 0) begin : g_src_in
      assign lanes_in = sigs_in;
    end else begin : g_src_prev
      assign lanes_in = g_lvl[k-1].data_q;
    end

    vx_tcu_drl_acc_level #(
      .LANES_IN(LIn),
      .W       (WIn)
    ) u_level (
      .lanes_i(lanes_in),
      .lanes_o(lanes_sum)
    );

    // Invalid beats never disturb the data registers.
    assign data_d = load[k] ? lanes_sum : data_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end
  end

  assign ready_in   = en[0];
  assign valid_out  = valid_q[LEVELS-1];
  assign sum_out    = g_lvl[LEVELS-1].data_q;
  assign sticky_out = sticky_q[LEVELS-1];
  assign is_int_out = is_int_q[LEVELS-1];
  assign req_id_out = req_q[LEVELS-1];

endmodule

// File: tb/tb_vx_tcu_drl_acc.sv
// Randomized and directed bench for vx_tcu_drl_acc against a queue-based reference model.
module tb_vx_tcu_drl_acc;

  localparam int unsigned N      = 5;
  localparam int unsigned WI     = 27;
  localparam int unsigned LEVELS = 3;
  localparam int unsigned WS     = 30;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid_in;
  logic              ready_in;
  logic [31:0]       req_id;
  logic              is_int;
  logic [N*WI-1:0]   sigs_in;
  logic [N-1:0]      sticky_in;
  logic              valid_out;
  logic              ready_out;
  logic [WS-1:0]     sum_out;
  logic              sticky_out;
  logic              is_int_out;
  logic [31:0]       req_id_out;

  vx_tcu_drl_acc #(
    .INSTANCE_ID("tb"),
    .N          (N),
    .WI         (WI)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .req_id    (req_id),
    .is_int    (is_int),
    .sigs_in   (sigs_in),
    .sticky_in (sticky_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .sum_out   (sum_out),
    .sticky_out(sticky_out),
    .is_int_out(is_int_out),
    .req_id_out(req_id_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] sum;
    logic          stk;
    logic [31:0]   tag;
    logic          isi;
    int            load;
    bit            has_lit;
    logic [WS-1:0] lit;
    logic          lit_stk;
  } beat_t;

  beat_t q[$];
  int    checks   = 0;
  int    failures = 0;
  int    edges    = 0;
  int    tag_ctr  = 1000;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: plain signed integer sum of all lanes, truncated to the output width.
  function automatic logic [WS-1:0] model_sum(input logic [N*WI-1:0] s);
    longint acc = 0;
    for (int i = 0; i < N; i++) begin
      acc += longint'($signed(s[i*WI +: WI]));
    end
    return acc[WS-1:0];
  endfunction

  // The oldest beat in flight is never blocked except at the output, so it must be
  // visible on valid_out from LEVELS-1 edges after the edge that captured it.
  task automatic cycle(input bit vin, input logic [N*WI-1:0] s, input logic [N-1:0] stk,
                       input logic [31:0] tag, input bit isi, input bit rdy,
                       input bit has_lit, input logic [WS-1:0] lit, input logic lit_stk);
    beat_t b;
    bit    exp_v;
    @(posedge clk);
    edges++;
    #1;
    exp_v = (q.size() > 0) && (edges >= q[0].load + int'(LEVELS) - 1);
    chk("valid_out", {63'd0, valid_out}, {63'd0, exp_v});
    if (exp_v && valid_out) begin
      chk("sum_out", {34'd0, sum_out}, {34'd0, q[0].sum});
      chk("sticky_out", {63'd0, sticky_out}, {63'd0, q[0].stk});
      chk("req_id_out", {32'd0, req_id_out}, {32'd0, q[0].tag});
      chk("is_int_out", {63'd0, is_int_out}, {63'd0, q[0].isi});
      if (q[0].has_lit) begin
        chk("sum_literal", {34'd0, sum_out}, {34'd0, q[0].lit});
        chk("sticky_literal", {63'd0, sticky_out}, {63'd0, q[0].lit_stk});
      end
    end
    valid_in  = vin;
    sigs_in   = s;
    sticky_in = stk;
    req_id    = tag;
    is_int    = isi;
    ready_out = rdy;
    #1;
    chk("ready_in", {63'd0, ready_in}, {63'd0, !(q.size() == int'(LEVELS) && !rdy)});
    if (valid_out && ready_out && q.size() > 0) void'(q.pop_front());
    if (valid_in && ready_in) begin
      b.sum     = model_sum(s);
      b.stk     = |stk;
      b.tag     = tag;
      b.isi     = isi;
      b.load    = edges + 1;
      b.has_lit = has_lit;
      b.lit     = lit;
      b.lit_stk = lit_stk;
      q.push_back(b);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 32'd0, 1'b0, rdy, 1'b0, '0, 1'b0);
  endtask

  task automatic beat(input logic [N*WI-1:0] s, input logic [N-1:0] stk, input logic [31:0] tag,
                      input bit rdy);
    cycle(1'b1, s, stk, tag, tag[0], rdy, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_valid_out"}, {63'd0, valid_out}, 64'd0);
    chk({pfx, "_sum_out"}, {34'd0, sum_out}, 64'd0);
    chk({pfx, "_sticky_out"}, {63'd0, sticky_out}, 64'd0);
    chk({pfx, "_is_int_out"}, {63'd0, is_int_out}, 64'd0);
    chk({pfx, "_req_id_out"}, {32'd0, req_id_out}, 64'd0);
  endtask

  function automatic logic [N*WI-1:0] rand_sigs();
    logic [N*WI-1:0] s;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       s[i*WI +: WI] = 27'h3FFFFFF;
        1:       s[i*WI +: WI] = 27'h4000000;
        default: s[i*WI +: WI] = WI'($urandom);
      endcase
    end
    return s;
  endfunction

  initial begin
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    sigs_in   = '0;
    sticky_in = '0;
    req_id    = '0;
    is_int    = 1'b0;
    ready_out = 1'b1;
    #2;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_in_after_reset", {63'd0, ready_in}, 64'd1);

    // Literal sums with known answers, sent back to back.
    cycle(1'b1, {27'd5, 27'd4, 27'd3, 27'd2, 27'd1}, 5'b00000, 32'd100, 1'b0, 1'b1,
          1'b1, 30'h000000F, 1'b0);
    cycle(1'b1, {5{27'h7FFFFFF}}, 5'b00100, 32'd101, 1'b1, 1'b1, 1'b1, 30'h3FFFFFFB, 1'b1);
    cycle(1'b1, {5{27'h3FFFFFF}}, 5'b00000, 32'd102, 1'b0, 1'b1, 1'b1, 30'h13FFFFFB, 1'b0);
    cycle(1'b1, {5{27'h4000000}}, 5'b10000, 32'd103, 1'b0, 1'b1, 1'b1, 30'h2C000000, 1'b1);
    idle(5, 1'b1);

    // Eight consecutive beats with a free-running sink.
    for (int i = 0; i < 8; i++) beat(rand_sigs(), N'($urandom), 32'(i), 1'b1);
    idle(5, 1'b1);

    // Stall after two beats: pipe fills, then drains in order.
    for (int i = 0; i < 2; i++) beat(rand_sigs(), '0, 32'(20 + i), 1'b1);
    for (int i = 0; i < 6; i++) beat(rand_sigs(), '0, 32'(22 + i), 1'b0);
    chk("stall_ready_in_low", {63'd0, ready_in}, 64'd0);
    idle(8, 1'b1);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) beat(rand_sigs(), 5'b00001, 32'(40 + i), 1'b0);
    @(posedge clk);
    #3;
    reset_n  = 1'b0;
    valid_in = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_in_after_midreset", {63'd0, ready_in}, 64'd1);
    idle(6, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] stk;
      stk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      cycle(($urandom_range(0, 9) < 7), rand_sigs(), stk, 32'(tag_ctr), 1'($urandom),
            ($urandom_range(0, 9) < 6), 1'b0, '0, 1'b0);
      tag_ctr++;
    end
    idle(10, 1'b1);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
